// File: rtl/des_cipher.sv
// Iterative single-DES engine: one Feistel round per clock, subkeys rolled on the fly.
// Decrypt starts from C0/D0 (equal to C16/D16) and right-rotates to walk K16..K1.
module des_cipher (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        e,
  input  logic [55:0] key,
  input  logic [63:0] in,
  output logic [63:0] out,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, out holds last result
  // RUN   | 16 rounds then one finalise cycle (rounds_left == 0)
  typedef enum logic {IDLE, RUN} state_t;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // Each box: 4 rows x 16 nibbles, entry (row*16+col) counted from the MSB end
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 64; n++) y[63-n] = x[64-IP_T[n]];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 64; n++) y[63-n] = x[64-FP_T[n]];
    return y;
  endfunction

  // Reinsert zero parity bits so PC-1 can use standard 1..64 bit numbers
  function automatic logic [55:0] pc1_f(input logic [55:0] k);
    logic [63:0] x;
    logic [55:0] y;
    x = '0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 7; i++) x[63-8*j-i] = k[55-7*j-i];
    for (int n = 0; n < 56; n++) y[55-n] = x[64-PC1_T[n]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] cd);
    logic [47:0] y;
    for (int n = 0; n < 48; n++) y[47-n] = cd[56-PC2_T[n]];
    return y;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] kk);
    logic [47:0]  x;
    logic [31:0]  s;
    logic [31:0]  y;
    logic [5:0]   six;
    logic [255:0] sel;
    for (int n = 0; n < 48; n++) x[47-n] = rr[32-E_T[n]];
    x = x ^ kk;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      sel = SBOX[b] << {six[5], six[0], six[4:1], 2'b00};
      s[31-4*b -: 4] = sel[255:252];
    end
    for (int n = 0; n < 32; n++) y[31-n] = s[32-P_T[n]];
    return y;
  endfunction

  state_t      state, state_nx;
  logic [31:0] l, r, f_out;
  logic [27:0] c, d, c_nx, d_nx;
  logic [47:0] k_sub;
  logic [4:0]  rounds_left;
  logic [1:0]  sh;
  logic        enc, load;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (rounds_left == 5'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    load = (state == IDLE) && start;
  end

  // rounds_left 16..1 maps to round 1..16
  always_comb begin
    case (rounds_left)
      5'd16:             sh = enc ? 2'd1 : 2'd0;
      5'd15, 5'd8, 5'd1: sh = 2'd1;
      default:           sh = 2'd2;
    endcase
    c_nx  = enc ? rotl(c, sh) : rotr(c, sh);
    d_nx  = enc ? rotl(d, sh) : rotr(d, sh);
    k_sub = pc2_f({c_nx, d_nx});
    f_out = feistel(r, k_sub);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l <= '0; r <= '0; c <= '0; d <= '0;
      enc <= 1'b0; rounds_left <= '0;
      out <= '0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        enc         <= e;
        {l, r}      <= ip_f(in);
        {c, d}      <= pc1_f(key);
        rounds_left <= 5'd16;
      end else if (busy) begin
        if (rounds_left != 5'd0) begin
          l           <= r;
          r           <= l ^ f_out;
          c           <= c_nx;
          d           <= d_nx;
          rounds_left <= rounds_left - 5'd1;
        end else begin
          out  <= fp_f({r, l});
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_cipher.sv
// Self-checking bench for des_cipher: known answers, control corner cases and
// randomized round trips against a bit-list DES model.
module tb_des_cipher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        e = 1'b0;
  logic [55:0] key = '0;
  logic [63:0] in_blk = '0;
  logic [63:0] out;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  des_cipher dut (.clk(clk), .rst_n(rst_n), .start(start), .e(e), .key(key),
                  .in(in_blk), .out(out), .busy(busy), .done(done));

  always #5 clk = ~clk;

  localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                             62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                             57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                             61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int EX [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                             16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int PP [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                              19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                              14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                              41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Textbook DES on 1-based bit lists; all 16 subkeys built up front, FP taken as IP inverse
  function automatic logic [63:0] des_ref(input logic [55:0] k56, input logic [63:0] blk, input logic enc);
    bit kb [1:64];
    bit cd [1:56];
    bit sub [1:16][1:48];
    bit lb [1:32];
    bit rb [1:32];
    bit nr [1:32];
    bit er [1:48];
    bit sb [1:32];
    bit y [1:64];
    bit t;
    int row, col, v, kk;
    logic [63:0] res;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 7; i++) kb[8*j+i+1] = k56[55-7*j-i];
      kb[8*j+8] = 1'b0;
    end
    for (int n = 1; n <= 56; n++) cd[n] = kb[PC1[n-1]];
    for (int rnd = 1; rnd <= 16; rnd++) begin
      for (int s = 0; s < SHIFTS[rnd-1]; s++) begin
        t = cd[1];
        for (int n = 1; n < 28; n++) cd[n] = cd[n+1];
        cd[28] = t;
        t = cd[29];
        for (int n = 29; n < 56; n++) cd[n] = cd[n+1];
        cd[56] = t;
      end
      for (int n = 1; n <= 48; n++) sub[rnd][n] = cd[PC2[n-1]];
    end
    for (int n = 1; n <= 32; n++) begin
      lb[n] = blk[64-IP[n-1]];
      rb[n] = blk[64-IP[n+31]];
    end
    for (int rnd = 1; rnd <= 16; rnd++) begin
      kk = enc ? rnd : 17 - rnd;
      for (int n = 1; n <= 48; n++) er[n] = rb[EX[n-1]] ^ sub[kk][n];
      for (int b = 0; b < 8; b++) begin
        row = 2*int'(er[6*b+1]) + int'(er[6*b+6]);
        col = 8*int'(er[6*b+2]) + 4*int'(er[6*b+3]) + 2*int'(er[6*b+4]) + int'(er[6*b+5]);
        v = SB[b][row*16+col];
        for (int q = 0; q < 4; q++) sb[4*b+1+q] = v[3-q];
      end
      for (int n = 1; n <= 32; n++) nr[n] = lb[n] ^ sb[PP[n-1]];
      lb = rb;
      rb = nr;
    end
    for (int n = 1; n <= 32; n++) begin
      y[n]    = rb[n];
      y[n+32] = lb[n];
    end
    for (int n = 1; n <= 64; n++) res[64-IP[n-1]] = y[n];
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    bcnt = int'(busy);
    lat  = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_block(input logic [55:0] k, input logic [63:0] b, input logic enc,
                           output logic [63:0] res, output int lat, output int bcnt);
    key = k; in_blk = b; e = enc; start = 1'b1;
    tick();
    start = 1'b0; key = ~k; in_blk = ~b; e = ~enc;
    wait_done(lat, bcnt);
    res = out;
    tick();
    check("done_pulse", 64'(done), 64'd0);
  endtask

  localparam logic [55:0] KAT_KEY = 56'h12695BC9B7B7F8;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

  initial begin
    logic [63:0] res, res2, pt;
    logic [55:0] k;
    int lat, bcnt, ndone, first_lat;

    rst_n = 1'b0; start = 1'b1; e = 1'b1; key = KAT_KEY; in_blk = KAT_PT;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out", out, 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    start = 1'b0; rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    run_block(KAT_KEY, KAT_PT, 1'b1, res, lat, bcnt);
    check("kat_enc", res, KAT_CT);
    check("kat_enc_lat", 64'(lat), 64'd17);
    check("kat_enc_busy", 64'(bcnt), 64'd17);
    check("out_hold", out, KAT_CT);

    run_block(KAT_KEY, KAT_CT, 1'b0, res, lat, bcnt);
    check("kat_dec", res, KAT_PT);
    check("kat_dec_lat", 64'(lat), 64'd17);

    run_block(56'd0, 64'd0, 1'b1, res, lat, bcnt);
    check("zero_enc", res, 64'h8CA64DE9C1B123A7);
    run_block(56'd0, res, 1'b0, res2, lat, bcnt);
    check("zero_dec", res2, 64'd0);

    // start re-asserted with other data while busy must be ignored
    key = KAT_KEY; in_blk = KAT_PT; e = 1'b1; start = 1'b1;
    tick();
    ndone = 0; first_lat = 0; res = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i >= 4 && i <= 7) begin
        start = 1'b1; key = 56'($urandom); in_blk = {$urandom, $urandom}; e = 1'b0;
      end else start = 1'b0;
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_lat = i;
          res = out;
        end
      end
    end
    check("ign_result", res, KAT_CT);
    check("ign_lat", 64'(first_lat), 64'd17);
    check("ign_ndone", 64'(ndone), 64'd1);

    // reset in the middle of a block aborts it
    key = KAT_KEY; in_blk = KAT_PT; e = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_ndone", 64'(ndone), 64'd0);
    check("abort_out", out, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);

    // back-to-back: second start issued in the done cycle
    k = 56'hA5A5_0F0F_3C3C_99; pt = 64'hDEAD_BEEF_0BAD_F00D;
    key = KAT_KEY; in_blk = KAT_PT; e = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt);
    check("b2b_first", out, KAT_CT);
    key = k; in_blk = pt; e = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd17);
    check("b2b_second", out, des_ref(k, pt, 1'b1));
    tick();

    for (int t = 0; t < 1000; t++) begin
      k  = {24'($urandom), $urandom};
      pt = {$urandom, $urandom};
      run_block(k, pt, 1'b1, res, lat, bcnt);
      check("rnd_enc", res, des_ref(k, pt, 1'b1));
      check("rnd_lat", 64'(lat), 64'd17);
      run_block(k, res, 1'b0, res2, lat, bcnt);
      check("rnd_dec", res2, pt);
      check("rnd_dec_ref", res2, des_ref(k, res, 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
